// File: rtl/shift.sv
// shift -- registered logical barrel shifter.
//
// Shifts an unsigned operand left or right by an unsigned amount in a
// single combinational pass, then captures the result on a strobed clock
// edge. Also reports whether any 1-bit fell off the end of the word.
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst_n    in   asynchronous active-low reset
//   num      in   [WIDTH-1:0] operand (unsigned)
//   d        in   direction: 0 = right (>>), 1 = left (<<)
//   s        in   [WIDTH-1:0] shift amount (unsigned)
//   en       in   capture strobe
//   y        out  [WIDTH-1:0] registered result
//   y_valid  out  high for one cycle after each capture
//   lost     out  registered: a 1-bit was discarded by the captured shift
//
// Handshake: en is a one-sided valid with no back-pressure. Every edge with
// en=1 captures num/d/s, and y/lost/y_valid reflect that capture during the
// following cycle. Edges with en=0 leave y/lost unchanged and drop y_valid.
module shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num,
  input  logic             d,
  input  logic [WIDTH-1:0] s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             lost
);

  // Number of barrel stages needed to cover every amount below WIDTH.
  localparam int LOG = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  logic             over_range;
  logic [WIDTH-1:0] shifted;
  logic             shifted_lost;

  // Any amount of WIDTH or more clears the word entirely; this also covers
  // non-power-of-two widths where the low LOG bits alone could exceed WIDTH.
  assign over_range = (s >= W_VAL);

  // Barrel shifter: stage k moves the word by 2^k when bit k of s is set.
  // The bits pushed out at each stage are OR-ed into the lost flag.
  always_comb begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] out_mask;
    logic             acc_lost;
    cur      = num;
    acc_lost = 1'b0;
    out_mask = '0;
    for (int k = 0; k < LOG; k++) begin
      if (s[k]) begin
        if (d) begin
          out_mask = ~({WIDTH{1'b1}} >> (1 << k));
          acc_lost = acc_lost | (|(cur & out_mask));
          cur      = cur << (1 << k);
        end else begin
          out_mask = ~({WIDTH{1'b1}} << (1 << k));
          acc_lost = acc_lost | (|(cur & out_mask));
          cur      = cur >> (1 << k);
        end
      end
    end
    if (over_range) begin
      shifted      = '0;
      shifted_lost = |num;
    end else begin
      shifted      = cur;
      shifted_lost = acc_lost;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      lost    <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= en;
      if (en) begin
        y    <= shifted;
        lost <= shifted_lost;
      end
    end
  end

endmodule

// File: tb/tb_shift.sv
// tb_shift -- self-checking bench for the shift block (WIDTH = 8).
//
// Directed table of {num, d, s, expected y, expected lost}, hand-written
// hold and reset sequences, then randomized traffic checked against an
// arithmetic reference model through an expected-result queue.
module tb_shift;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] num;
  logic         d;
  logic [W-1:0] s;
  logic         en;
  logic [W-1:0] y;
  logic         y_valid;
  logic         lost;

  int checks = 0;
  int errors = 0;

  shift #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .num     (num),
    .d       (d),
    .s       (s),
    .en      (en),
    .y       (y),
    .y_valid (y_valid),
    .lost    (lost)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain arithmetic: shift with the language operators, then detect lost
  // bits by undoing the shift and comparing with the original operand.
  function automatic logic [W:0] ref_shift(input logic [W-1:0] n,
                                           input logic dir,
                                           input logic [W-1:0] amt);
    logic [W-1:0] r;
    logic         l;
    int           a;
    a = int'(amt);
    if (a >= W) begin
      r = '0;
      l = (n != 0);
    end else if (dir) begin
      r = n << a;
      l = ((r >> a) != n);
    end else begin
      r = n >> a;
      l = ((r << a) != n);
    end
    return {l, r};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [W-1:0] n, input logic dir,
                       input logic [W-1:0] amt, input logic strobe);
    num = n;
    d   = dir;
    s   = amt;
    en  = strobe;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] num;
    logic         d;
    logic [W-1:0] s;
    logic [W-1:0] y;
    logic         lost;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  // Scoreboard queue of expected {lost, y}.
  logic [W:0] exp_q[$];

  initial begin
    logic [W:0]   e;
    logic [W-1:0] held_y;
    logic         held_lost;
    logic         r_en;
    logic [W-1:0] r_num;
    logic [W-1:0] r_s;
    logic         r_d;

    vecs[0]  = '{8'd10, 1'b0, 8'd1,   8'd5,  1'b0};
    vecs[1]  = '{8'd5,  1'b1, 8'd1,   8'd10, 1'b0};
    vecs[2]  = '{8'h81, 1'b1, 8'd1,   8'h02, 1'b1};
    vecs[3]  = '{8'h81, 1'b0, 8'd1,   8'h40, 1'b1};
    vecs[4]  = '{8'hFF, 1'b0, 8'd8,   8'h00, 1'b1};
    vecs[5]  = '{8'hFF, 1'b1, 8'd8,   8'h00, 1'b1};
    vecs[6]  = '{8'h3C, 1'b0, 8'd0,   8'h3C, 1'b0};
    vecs[7]  = '{8'h3C, 1'b1, 8'd0,   8'h3C, 1'b0};
    vecs[8]  = '{8'h00, 1'b1, 8'd200, 8'h00, 1'b0};
    vecs[9]  = '{8'h80, 1'b1, 8'd1,   8'h00, 1'b1};
    vecs[10] = '{8'h01, 1'b0, 8'd1,   8'h00, 1'b1};
    vecs[11] = '{8'hF0, 1'b0, 8'd4,   8'h0F, 1'b0};
    vecs[12] = '{8'h0F, 1'b1, 8'd4,   8'hF0, 1'b0};
    vecs[13] = '{8'h01, 1'b1, 8'd7,   8'h80, 1'b0};
    vecs[14] = '{8'h80, 1'b0, 8'd7,   8'h01, 1'b0};
    vecs[15] = '{8'h01, 1'b1, 8'd255, 8'h00, 1'b1};

    // ---- reset ----
    rst_n = 1'b0;
    num = '0; d = 1'b0; s = '0; en = 1'b0;
    #3;
    check("reset_y", 32'(y), 32'd0);
    check("reset_lost", 32'(lost), 32'd0);
    check("reset_valid", 32'(y_valid), 32'd0);
    // Capture attempted while reset is still low must not take effect.
    num = 8'hAA; s = 8'd1; en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold_y", 32'(y), 32'd0);
    check("reset_hold_valid", 32'(y_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    // ---- table, back-to-back captures ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].num, vecs[i].d, vecs[i].s, 1'b1);
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d_lost", i), 32'(lost), 32'(vecs[i].lost));
      check($sformatf("vec%0d_valid", i), 32'(y_valid), 32'd1);
    end

    // ---- hold: capture 10, then en=0 for three cycles with inputs moving ----
    drive(8'd5, 1'b1, 8'd1, 1'b1);
    check("hold_cap_y", 32'(y), 32'd10);
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'b0);
      check($sformatf("hold%0d_y", i), 32'(y), 32'd10);
      check($sformatf("hold%0d_lost", i), 32'(lost), 32'd0);
      check($sformatf("hold%0d_valid", i), 32'(y_valid), 32'd0);
    end

    // ---- inputs changing between edges do not leak to outputs ----
    @(negedge clk);
    num = 8'hFF; s = 8'd3; d = 1'b1; en = 1'b1;
    #2;
    check("between_edges_y", 32'(y), 32'd10);
    en = 1'b0;

    // ---- mid-stream async reset ----
    drive(8'd10, 1'b0, 8'd1, 1'b1);
    check("pre_rst_y", 32'(y), 32'd5);
    num = 8'h81; d = 1'b1; s = 8'd1; en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", 32'(y), 32'd0);
    check("async_rst_lost", 32'(lost), 32'd0);
    check("async_rst_valid", 32'(y_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'd6, 1'b0, 8'd1, 1'b1);
    check("post_rst_y", 32'(y), 32'd3);
    check("post_rst_lost", 32'(lost), 32'd0);
    check("post_rst_valid", 32'(y_valid), 32'd1);

    // ---- randomized traffic against the reference model ----
    held_y    = y;
    held_lost = lost;
    for (int i = 0; i < 400; i++) begin
      r_en  = ($urandom_range(0, 3) != 0);
      r_num = 8'($urandom_range(0, 255));
      r_d   = 1'($urandom_range(0, 1));
      r_s   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                          : 8'($urandom_range(0, W));
      if (r_en) exp_q.push_back(ref_shift(r_num, r_d, r_s));
      drive(r_num, r_d, r_s, r_en);
      if (r_en) begin
        e = exp_q.pop_front();
        held_y    = e[W-1:0];
        held_lost = e[W];
      end
      check($sformatf("rnd%0d_y n=%0h d=%0d s=%0d", i, r_num, r_d, r_s),
            32'(y), 32'(held_y));
      check($sformatf("rnd%0d_lost", i), 32'(lost), 32'(held_lost));
      check($sformatf("rnd%0d_valid", i), 32'(y_valid), 32'(r_en));
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
